// File: rtl/led_seq_ctrl.sv
// Status-LED sequencer: steps through up to four (level, duration) entries,
// driving the data/output-enable pair of a tristate pin from a built-in tick divider.
module led_seq_ctrl #(
    parameter int TICK_DIV = 2560000,
    parameter int DUR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [1:0]       cfg_level,
    input  logic [DUR_W-1:0] cfg_dur,
    input  logic [1:0]       cfg_last,
    input  logic             cfg_loop,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic [1:0]       step_idx,
    output logic             led_o,
    output logic             led_oe
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DUR_W-1:0]   rem_q, rem_d;
    logic [1:0]         idx_q, idx_d;
    logic [1:0]         last_q, last_d;
    logic               loop_q, loop_d;
    logic               done_q, done_d;
    logic               led_o_q, led_o_d;
    logic               led_oe_q, led_oe_d;
    logic [1:0]         lvl_q [4];
    logic [1:0]         lvl_d [4];
    logic [DUR_W-1:0]   dur_q [4];
    logic [DUR_W-1:0]   dur_d [4];

    logic               tick;
    logic [1:0]         nxt_idx;

    // Returns {led_o, led_oe}; the reserved code falls back to off.
    function automatic logic [1:0] lvl_pins(input logic [1:0] lvl);
        case (lvl)
            2'b01:   return 2'b10;
            2'b10:   return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        last_d   = last_q;
        loop_d   = loop_q;
        done_d   = 1'b0;
        led_o_d  = led_o_q;
        led_oe_d = led_oe_q;
        lvl_d    = lvl_q;
        dur_d    = dur_q;
        tick     = (cnt_q == CNT_MAX);
        nxt_idx  = idx_q + 2'd1;

        if (cfg_we && state_q == S_IDLE) begin
            lvl_d[cfg_addr] = cfg_level;
            dur_d[cfg_addr] = cfg_dur;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d               = '0;
                idx_d               = 2'd0;
                {led_o_d, led_oe_d} = 2'b11;
                if (start && !stop) begin
                    // Reads the pre-write table so a same-cycle write to step 0 is not seen.
                    state_d             = S_RUN;
                    last_d              = cfg_last;
                    loop_d              = cfg_loop;
                    rem_d               = dur_q[0];
                    {led_o_d, led_oe_d} = lvl_pins(lvl_q[0]);
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d             = S_IDLE;
                    cnt_d               = '0;
                    idx_d               = 2'd0;
                    {led_o_d, led_oe_d} = 2'b11;
                end else begin
                    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
                    if (tick) begin
                        if (rem_q != '0) begin
                            rem_d = rem_q - DUR_W'(1);
                        end else if (idx_q != last_q) begin
                            idx_d               = nxt_idx;
                            rem_d               = dur_q[nxt_idx];
                            {led_o_d, led_oe_d} = lvl_pins(lvl_q[nxt_idx]);
                        end else if (loop_q) begin
                            idx_d               = 2'd0;
                            rem_d               = dur_q[0];
                            {led_o_d, led_oe_d} = lvl_pins(lvl_q[0]);
                        end else begin
                            state_d             = S_IDLE;
                            done_d              = 1'b1;
                            cnt_d               = '0;
                            idx_d               = 2'd0;
                            {led_o_d, led_oe_d} = 2'b11;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            idx_q    <= 2'd0;
            last_q   <= 2'd0;
            loop_q   <= 1'b0;
            done_q   <= 1'b0;
            led_o_q  <= 1'b1;
            led_oe_q <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                lvl_q[i] <= 2'b00;
                dur_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            loop_q   <= loop_d;
            done_q   <= done_d;
            led_o_q  <= led_o_d;
            led_oe_q <= led_oe_d;
            lvl_q    <= lvl_d;
            dur_q    <= dur_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = done_q;
    assign step_idx = idx_q;
    assign led_o    = led_o_q;
    assign led_oe   = led_oe_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl with a short tick (4 clocks); per-cycle expectations
// are queued as stimulus is driven and compared after each clock edge.
module tb_led_seq_ctrl;

    localparam int TD    = 4;
    localparam int DUR_W = 8;

    logic             clk;
    logic             rst;
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [1:0]       cfg_level;
    logic [DUR_W-1:0] cfg_dur;
    logic [1:0]       cfg_last;
    logic             cfg_loop;
    logic             start;
    logic             stop;
    logic             busy;
    logic             done;
    logic [1:0]       step_idx;
    logic             led_o;
    logic             led_oe;

    led_seq_ctrl #(.TICK_DIV(TD), .DUR_W(DUR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_level (cfg_level),
        .cfg_dur   (cfg_dur),
        .cfg_last  (cfg_last),
        .cfg_loop  (cfg_loop),
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .step_idx  (step_idx),
        .led_o     (led_o),
        .led_oe    (led_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] lvl;
        logic       led_o;
        logic       led_oe;
    } vec_t;

    typedef struct {
        logic       busy;
        logic       done;
        logic [1:0] idx;
        logic       led_o;
        logic       led_oe;
        string      nm;
    } exp_t;

    vec_t       vecs [4];
    exp_t       sb_q [$];
    logic [1:0] tb_lvl [4];
    int         tb_dur [4];
    int         n_checks;
    int         n_errors;
    int         ran;

    task automatic check_cycle(input logic b, input logic d, input logic [1:0] idx,
                               input logic [1:0] lvl, input string nm);
        exp_t e;
        exp_t g;
        e.busy   = b;
        e.done   = d;
        e.idx    = idx;
        e.led_o  = vecs[lvl].led_o;
        e.led_oe = vecs[lvl].led_oe;
        e.nm     = nm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        n_checks++;
        if (busy !== g.busy || done !== g.done || led_o !== g.led_o || led_oe !== g.led_oe ||
            (g.busy && step_idx !== g.idx)) begin
            n_errors++;
            $display("FAIL %s @%0t: got busy=%b done=%b idx=%0d led_o=%b led_oe=%b, want busy=%b done=%b idx=%0d led_o=%b led_oe=%b",
                     g.nm, $time, busy, done, step_idx, led_o, led_oe,
                     g.busy, g.done, g.idx, g.led_o, g.led_oe);
        end
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [1:0] lvl, input int dur);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_level = lvl;
        cfg_dur   = DUR_W'(dur);
        check_cycle(1'b0, 1'b0, 2'd0, 2'd0, "cfg_write");
        cfg_we       = 1'b0;
        tb_lvl[addr] = lvl;
        tb_dur[addr] = dur;
    endtask

    // Starts a sequence and checks every cycle of it; returns early after max_cyc
    // cycles with the DUT still running. we_busy holds a table write through the run.
    task automatic run_expect(input logic [1:0] last, input bit loop, input int max_cyc,
                              input bit we_busy, output int n);
        int k;
        int c_in;
        k        = 0;
        c_in     = 0;
        n        = 0;
        cfg_last = last;
        cfg_loop = loop;
        start    = 1'b1;
        while (n < max_cyc) begin
            check_cycle(1'b1, 1'b0, 2'(k), tb_lvl[k], "run");
            n++;
            if (n == 1) begin
                start    = 1'b0;
                cfg_last = 2'd0;
                cfg_loop = 1'b0;
                if (we_busy) cfg_we = 1'b1;
            end
            c_in++;
            if (c_in == (tb_dur[k] + 1) * TD) begin
                c_in = 0;
                if (k == int'(last)) begin
                    if (!loop) break;
                    k = 0;
                end else begin
                    k++;
                end
            end
        end
        cfg_we = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{lvl: 2'b00, led_o: 1'b1, led_oe: 1'b1};
        vecs[1] = '{lvl: 2'b01, led_o: 1'b1, led_oe: 1'b0};
        vecs[2] = '{lvl: 2'b10, led_o: 1'b0, led_oe: 1'b1};
        vecs[3] = '{lvl: 2'b11, led_o: 1'b1, led_oe: 1'b1};
        for (int i = 0; i < 4; i++) begin
            tb_lvl[i] = 2'b00;
            tb_dur[i] = 0;
        end
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_level = 2'd0;
        cfg_dur   = '0;
        cfg_last  = 2'd0;
        cfg_loop  = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;

        check_cycle(1'b0, 1'b0, 2'd0, 2'd0, "reset");
        check_cycle(1'b0, 1'b0, 2'd0, 2'd0, "reset");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) check_cycle(1'b0, 1'b0, 2'd0, 2'd0, "idle");

        // Level encoding: one single-step sequence per table vector.
        for (int i = 0; i < 4; i++) begin
            cfg_write(2'd0, vecs[i].lvl, 0);
            run_expect(2'd0, 1'b0, 1000, 1'b0, ran);
            check_cycle(1'b0, 1'b1, 2'd0, 2'd0, "level_done");
        end

        cfg_write(2'd0, 2'b00, 1);
        cfg_write(2'd1, 2'b01, 0);
        cfg_write(2'd2, 2'b10, 2);

        run_expect(2'd2, 1'b0, 1000, 1'b0, ran);
        check_cycle(1'b0, 1'b1, 2'd0, 2'd0, "seq_done");
        check_cycle(1'b0, 1'b0, 2'd0, 2'd0, "seq_after_done");

        run_expect(2'd2, 1'b1, 60, 1'b0, ran);
        stop = 1'b1;
        check_cycle(1'b0, 1'b0, 2'd0, 2'd0, "loop_stop");
        stop = 1'b0;

        // Write to step 1 while busy must be dropped.
        cfg_addr  = 2'd1;
        cfg_level = 2'b10;
        cfg_dur   = DUR_W'(3);
        run_expect(2'd2, 1'b0, 1000, 1'b1, ran);
        check_cycle(1'b0, 1'b1, 2'd0, 2'd0, "we_busy_done");
        check_cycle(1'b0, 1'b0, 2'd0, 2'd0, "we_busy_idle");

        cfg_write(2'd1, 2'b10, 3);
        run_expect(2'd2, 1'b0, 1000, 1'b0, ran);
        check_cycle(1'b0, 1'b1, 2'd0, 2'd0, "rewrite_done");

        // Stop 5 cycles into step 1, then restart from step 0.
        run_expect(2'd2, 1'b0, 8 + 5, 1'b0, ran);
        stop = 1'b1;
        check_cycle(1'b0, 1'b0, 2'd0, 2'd0, "stop_mid");
        stop = 1'b0;
        check_cycle(1'b0, 1'b0, 2'd0, 2'd0, "stop_idle");
        run_expect(2'd2, 1'b0, 1000, 1'b0, ran);
        check_cycle(1'b0, 1'b1, 2'd0, 2'd0, "restart_done");

        start = 1'b1;
        stop  = 1'b1;
        check_cycle(1'b0, 1'b0, 2'd0, 2'd0, "start_stop");
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 3; i++) check_cycle(1'b0, 1'b0, 2'd0, 2'd0, "start_stop_idle");

        // Reset in step 2 clears the table too.
        run_expect(2'd2, 1'b0, 8 + 16 + 3, 1'b0, ran);
        rst = 1'b1;
        check_cycle(1'b0, 1'b0, 2'd0, 2'd0, "rst_mid");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tb_lvl[i] = 2'b00;
            tb_dur[i] = 0;
        end
        run_expect(2'd2, 1'b0, 1000, 1'b0, ran);
        check_cycle(1'b0, 1'b1, 2'd0, 2'd0, "post_rst_done");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
